pbus_initiator: RTL

// - Initiator (master) side of the peripheral memory bus (valid/addr/write/wdata/wstrb -> rdata/ready).
// - Drives peripheral subsystems such as the GPIO subsystem.
// - Accepts commands through a valid/ready command port into a small FIFO.
// - Issues one bus transaction per command, in order.
// - Returns one response per command on a valid/ready response port.
// - A bus watchdog aborts transactions that never see bus_ready.

---
 rtl/pbus_initiator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pbus_initiator.sv
// pbus_initiator
//   Initiator side of the peripheral memory bus. Commands are queued in a
//   small FIFO and issued one at a time, in order. Each command produces
//   exactly one response. A watchdog aborts any transaction whose responder
//   never raises bus_ready.
//
// Ports
//   sys_clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_addr/write/wdata/wstrb      command fields (wstrb ignored on reads)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              read data (0 on writes/timeouts), timeout flag
//   bus_valid/addr/write/wdata/wstrb registered peripheral bus request
//   bus_rdata, bus_ready            responder data and single-cycle completion
//   busy                            any queued, in-flight or unconsumed work
module pbus_initiator #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255,
    parameter int ADDR_W    = 24
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready,
    output logic              busy
);

    localparam int              PTR_W    = $clog2(CMD_DEPTH);
    localparam int              ENT_W    = ADDR_W + 37;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);
    localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0] fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, fifo_empty;
    logic [ENT_W-1:0] head;
    logic [15:0]      watchdog;
    logic             issue, bus_done, bus_timeout, rsp_take;

    assign cmd_ready  = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];
    assign busy       = !fifo_empty || (state != IDLE) || rsp_valid;

    // FIFO payload storage; no reset needed since count gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_addr, cmd_write, cmd_wdata, cmd_wstrb};
        end
    end

    // FIFO pointers and occupancy. cmd_ready is derived from the registered
    // count, so a simultaneous pop while full does not reopen the port.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !issue) begin
                count <= count + 1'b1;
            end else if (!push && issue) begin
                count <= count - 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. RESP also leaves when the response was already taken
    // during GAP (consumer had rsp_ready high as rsp_valid rose).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!fifo_empty && !rsp_valid) state_nxt = REQ;
            REQ:  if (bus_ready || (watchdog == WD_LAST)) state_nxt = GAP;
            GAP:  state_nxt = RESP;
            RESP: if (!rsp_valid || rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes. A bus_ready in the expiry cycle counts as success.
    always_comb begin
        issue       = 1'b0;
        bus_done    = 1'b0;
        bus_timeout = 1'b0;
        rsp_take    = rsp_valid && rsp_ready;
        case (state)
            IDLE: issue = !fifo_empty && !rsp_valid;
            REQ: begin
                bus_done    = bus_ready;
                bus_timeout = !bus_ready && (watchdog == WD_LAST);
            end
            default: ;
        endcase
    end

    // Registered bus request; fields only change when a new command issues,
    // so they stay stable for the whole time bus_valid is high.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_write <= 1'b0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else if (issue) begin
            bus_valid <= 1'b1;
            bus_addr  <= head[ENT_W-1 -: ADDR_W];
            bus_write <= head[36];
            bus_wdata <= head[35:4];
            bus_wstrb <= head[36] ? head[3:0] : 4'h0;
        end else if (bus_done || bus_timeout) begin
            bus_valid <= 1'b0;
        end
    end

    // Watchdog: cleared on entry to REQ, counts REQ cycles, saturates.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            watchdog <= '0;
        end else if (issue) begin
            watchdog <= '0;
        end else if ((state == REQ) && (watchdog != 16'hFFFF)) begin
            watchdog <= watchdog + 16'd1;
        end
    end

    // Response register, held until the consumer accepts it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (bus_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= bus_write ? 32'h0 : bus_rdata;
            rsp_err   <= 1'b0;
        end else if (bus_timeout) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
